// File: rtl/ssd_display_driver.sv
// Four-digit seven-segment driver: converts a 13-bit binary value to BCD
// with a shift-and-add-3 FSM, then time-multiplexes the digits onto the
// active-low anode/segment lines.
module ssd_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] num,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic [15:0] bcd,
  output logic        busy
);

  localparam int unsigned NUM_W  = 13;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned ITER_W = 4;
  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [ITER_W-1:0] ITERS    = ITER_W'(NUM_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]        SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic [NUM_W-1:0]    src_q, src_d;
  logic [NUM_W-1:0]    shift_q, shift_d;
  logic [BCD_W-1:0]    scratch_q, scratch_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [BCD_W-1:0]    bcd_d;
  logic                busy_d;

  logic [CNT_W-1:0]    refresh_q;
  logic [1:0]          digit_q;
  logic [3:0]          nibble;
  logic                upper_zero;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the doubling shift
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Converter state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      src_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd       <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      src_q     <= src_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      bcd       <= bcd_d;
      busy      <= busy_d;
    end
  end

  // Next-state and datapath for the binary-to-BCD conversion
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    src_d     = src_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd;
    case (state_q)
      IDLE: begin
        if (!valid_q || (num != src_q)) state_d = LOAD;
      end
      LOAD: begin
        src_d     = num;
        shift_d   = num;
        scratch_d = '0;
        iter_d    = ITERS;
        state_d   = SHIFT;
      end
      SHIFT: begin
        {scratch_d, shift_d} = {add3(scratch_q), shift_q} << 1;
        iter_d = iter_q - ITER_W'(1);
        if (iter_q == ITER_W'(1)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = scratch_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Refresh timer and digit scan; anode rotates with the digit index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_q <= '0;
      digit_q   <= 2'd0;
      anode     <= 4'b1110;
    end else if (refresh_q == CNT_LAST) begin
      refresh_q <= '0;
      digit_q   <= digit_q + 2'd1;
      anode     <= {anode[2:0], anode[3]};
    end else begin
      refresh_q <= refresh_q + CNT_W'(1);
    end
  end

  // Select the lit digit's nibble and whether all digits above it are zero
  always_comb begin
    nibble     = bcd[3:0];
    upper_zero = 1'b0;
    case (digit_q)
      2'd0: begin nibble = bcd[3:0];   upper_zero = 1'b0;              end
      2'd1: begin nibble = bcd[7:4];   upper_zero = (bcd[15:4]  == '0); end
      2'd2: begin nibble = bcd[11:8];  upper_zero = (bcd[15:8]  == '0); end
      2'd3: begin nibble = bcd[15:12]; upper_zero = (bcd[15:12] == '0); end
      default: begin nibble = bcd[3:0]; upper_zero = 1'b0;             end
    endcase
  end

  // Segment decode ({g,f,e,d,c,b,a}, active low) with leading-zero blanking
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    if (BLANK_LZ && upper_zero) seg = SEG_BLANK;
  end

endmodule

// File: tb/tb_ssd_display_driver.sv
// Randomized scoreboard bench for ssd_display_driver with a transaction-level
// reference model; runs one instance with and one without zero blanking.
module tb_ssd_display_driver;

  localparam int unsigned DIV = 4;

  logic        clk;
  logic        rst;
  logic [12:0] num;
  logic [3:0]  anode,  anode0;
  logic [6:0]  seg,    seg0;
  logic [15:0] bcd,    bcd0;
  logic        busy,   busy0;

  ssd_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .num(num),
    .anode(anode), .seg(seg), .bcd(bcd), .busy(busy)
  );

  ssd_display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .num(num),
    .anode(anode0), .seg(seg0), .bcd(bcd0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input bit blz);
    logic [15:0] hi;
    int nib;
    hi  = v >> (4 * d);
    nib = int'(hi & 16'hF);
    if (blz && d != 0 && hi == 16'h0) return 7'b1111111;
    if (nib > 9) return 7'b1111111;
    return seg_tab[nib];
  endfunction

  // Reference model: a conversion is decided on one edge, samples num on the
  // next, and publishes its result 15 edges after the decision.
  logic [15:0] q[$];
  int          m_rem;
  bit          m_cap;
  bit          m_valid;
  int          m_held;
  bit          m_busy;
  logic [15:0] m_bcd;
  int          m_n;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rem = 0; m_cap = 0; m_valid = 0; m_held = 0;
      m_busy = 0; m_bcd = 16'h0; m_n = 0;
      q.delete();
    end else begin
      cyc++;
      m_n++;
      if (m_rem == 0) begin
        if (!m_valid || int'(num) != m_held) begin
          m_rem  = 15;
          m_busy = 1;
          m_cap  = 1;
        end
      end else begin
        if (m_cap) begin
          m_held = int'(num);
          m_cap  = 0;
          q.push_back(to_bcd(m_held));
        end
        m_rem--;
        if (m_rem == 0) begin
          m_bcd   = to_bcd(m_held);
          m_valid = 1;
          m_busy  = 0;
        end
      end
    end
  end

  // Monitor: per-cycle output checks, and scoreboard pop on each completion
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    int d;
    logic [15:0] e;
    if (rst) begin
      d = (m_n / DIV) % 4;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("bcd", 32'(bcd), 32'(m_bcd));
      chk("bcd_nb", 32'(bcd0), 32'(m_bcd));
      chk("anode", 32'(anode), 32'(4'b1111 & ~(4'b0001 << d)));
      chk("anode_nb", 32'(anode0), 32'(4'b1111 & ~(4'b0001 << d)));
      chk("seg", 32'(seg), 32'(exp_seg(m_bcd, d, 1'b1)));
      chk("seg_nb", 32'(seg0), 32'(exp_seg(m_bcd, d, 1'b0)));
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          chk("conv_unexpected", 32'(bcd), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("conv", 32'(bcd), 32'(e));
        end
      end
      prev_busy = busy;
    end else begin
      prev_busy = 1'b0;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    num = 13'd1234;
    wait_cycles(3);
    // Reset state
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_anode", 32'(anode), 32'hE);
    chk("rst_seg", 32'(seg), 32'h40);
    rst = 1'b1;
    wait_cycles(1);
    chk("start_busy", 32'(busy), 32'h1);
    wait_cycles(15);
    chk("bcd_1234", 32'(bcd), 32'h1234);
    wait_cycles(30);

    num = 13'd7;     wait_cycles(40);
    num = 13'd8191;  wait_cycles(20);
    chk("bcd_8191", 32'(bcd), 32'h8191);
    num = 13'd0;     wait_cycles(40);

    // Change the value while a conversion is in flight
    num = 13'd100;   wait_cycles(7);
    num = 13'd200;   wait_cycles(12);
    chk("bcd_100", 32'(bcd), 32'h0100);
    wait_cycles(20);
    chk("bcd_200", 32'(bcd), 32'h0200);

    // Asynchronous reset during a conversion
    num = 13'd4095;  wait_cycles(9);
    rst = 1'b0;
    #1;
    chk("arst_bcd", 32'(bcd), 32'h0);
    chk("arst_anode", 32'(anode), 32'hE);
    chk("arst_busy", 32'(busy), 32'h0);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(16);
    chk("bcd_4095", 32'(bcd), 32'h4095);

    // Long hold: nothing should restart
    wait_cycles(1000);

    // Randomized values and hold times
    for (int i = 0; i < 40; i++) begin
      num = 13'($urandom_range(0, 8191));
      wait_cycles(int'($urandom_range(1, 40)));
    end
    wait_cycles(40);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd_display_driver.md
SSD_DISPLAY_DRIVER -- requirements
Module: ssd_display_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000: clk cycles each digit is lit; legal range 2..2^20.
REQ-002 The block SHALL have parameter BLANK_LZ, default 1: 1 = leading-zero blanking on, 0 = off.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port num, input, 13 bits: unsigned value to display (the processor's ssd debug output).
REQ-006 The block SHALL have port anode, output, 4 bits: active-low digit enables; bit 0 = units, bit 3 = thousands.
REQ-007 The block SHALL have port seg, output, 7 bits: active-low cathodes, ordered {g,f,e,d,c,b,a}.
REQ-008 The block SHALL have port bcd, output, 16 bits: displayed value as 4 BCD digits, thousands in [15:12].
REQ-009 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.

Function
REQ-010 The converter SHALL be an FSM with states IDLE, LOAD, SHIFT and DONE.
REQ-011 In IDLE, the FSM SHALL go to LOAD when the valid flag is 0 or num differs from the held source value; otherwise it SHALL stay in IDLE.
REQ-012 LOAD SHALL capture num into the source register, clear the 16-bit scratch BCD, and set the iteration count to 13.
REQ-013 Each SHIFT cycle SHALL add 3 to every scratch nibble that is >= 5, then shift {scratch, source} left one bit and decrement the count; SHIFT SHALL last exactly 13 cycles.
REQ-014 DONE SHALL copy the scratch BCD to the bcd output, set the valid flag, and return to IDLE; total latency SHALL be 15 cycles from the IDLE decision to the bcd update.
REQ-015 busy SHALL be high in LOAD, SHIFT and DONE, and low in IDLE.
REQ-016 Changes on num while busy is high SHALL be ignored; the IDLE comparison after DONE SHALL detect them and restart the conversion on the next cycle.
REQ-017 The bcd output SHALL change only in DONE, as one atomic update; a partial result SHALL never be displayed.
REQ-018 The maximum num value 8191 SHALL convert to bcd 16'h8191; no overflow is possible.
REQ-019 The refresh counter SHALL count 0..REFRESH_DIV-1; at the terminal count it SHALL wrap to 0 and advance the digit index 0->1->2->3->0.
REQ-020 anode SHALL have exactly one bit low, the bit equal to the digit index, on every cycle out of reset.
REQ-021 seg SHALL be decoded combinationally from the bcd nibble selected by the digit index.
REQ-022 The seg codes SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 A nibble above 9 SHALL decode to blank (1111111); this SHALL never occur in normal operation.
REQ-024 With BLANK_LZ=1, a digit SHALL show blank (1111111) when it and every higher digit are zero; the units digit SHALL never be blanked.
REQ-025 The anode and seg outputs SHALL be free of combinational paths from num.

Reset
REQ-026 While rst=0, the block SHALL force: state IDLE, valid 0, source 0, scratch 0, bcd 16'h0000, busy 0, refresh counter 0, digit index 0, anode 4'b1110, seg 1000000.
REQ-027 Assertion of rst SHALL take effect immediately, including mid-conversion; the partial result SHALL be discarded.
REQ-028 After rst deasserts, the first conversion SHALL start on the first clock edge, whatever the value of num, because valid is 0.

Verification
REQ-029 Scenario (REFRESH_DIV=4): hold num=1234 through reset release -> busy high for 15 cycles, then bcd=16'h1234; anode steps 1110, 1101, 1011, 0111 every 4 cycles; seg shows 4, 3, 2, 1 in that order.
REQ-030 Scenario: num=7 with BLANK_LZ=1 -> digits 1-3 show seg 1111111 and digit 0 shows 1111000; with BLANK_LZ=0 -> digits 1-3 show 1000000.
REQ-031 Scenario: num=8191 -> bcd=16'h8191; then num=0 -> bcd=16'h0000 and the display shows a single 0 in the units digit.
REQ-032 Scenario: num changes 100->200 at SHIFT cycle 5 -> bcd=16'h0100 at DONE, busy low for 1 cycle, then a new conversion gives bcd=16'h0200 after 15 more cycles.
REQ-033 Scenario: rst pulsed low at SHIFT cycle 7 of num=4095 -> bcd=0 and anode=1110 at once; after release, bcd=16'h4095 15 cycles later.
REQ-034 Scenario: num held constant for 1000 cycles after conversion -> busy stays low and bcd stays stable throughout.
